// File: rtl/mcalu.sv
// mcalu: iterative RV32M multiply/divide/remainder unit.
// Accepts one op at a time. The op spends 32 cycles in CALC, then the result
// is presented to writeback with a valid/stall handshake.
module mcalu (
    input  logic        clk,
    input  logic        rst,
    input  logic        exers_mcalu_issue,
    input  logic [4:0]  exers_mcalu_op,
    input  logic [6:0]  exers_robid,
    input  logic [5:0]  exers_rd,
    input  logic [31:0] exers_op1,
    input  logic [31:0] exers_op2,
    output logic        mcalu_stall,
    output logic        mcalu_valid,
    output logic [6:0]  mcalu_robid,
    output logic [5:0]  mcalu_rd,
    output logic [31:0] mcalu_result,
    input  logic        wb_mcalu_stall,
    input  logic        rob_flush
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [6:0]  robid_q, robid_d;
    logic [5:0]  rd_q, rd_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic [31:0] result_q, result_d;

    logic        isMcaluOp;
    logic        isMul;
    logic        signA;
    logic        signB;
    logic        negA;
    logic        negB;
    logic [31:0] absA;
    logic [31:0] absB;
    logic        issueNeg;

    logic [32:0] mulSum;
    logic [63:0] mulNext;
    logic [32:0] divShifted;
    logic        divGeq;
    logic [31:0] divSub;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic [63:0] prodFixed;
    logic [31:0] quoFixed;
    logic [31:0] remFixed;
    logic [31:0] finalResult;

    // Decode the incoming op: which operands are signed, their magnitudes and the result sign.
    always_comb begin
        isMcaluOp = (exers_mcalu_op[4:3] == 2'b11);
        isMul     = ~exers_mcalu_op[2];
        if (isMul) begin
            signA = (exers_mcalu_op[2:0] == 3'b001) || (exers_mcalu_op[2:0] == 3'b010);
            signB = (exers_mcalu_op[2:0] == 3'b001);
        end else begin
            signA = ~exers_mcalu_op[0];
            signB = ~exers_mcalu_op[0];
        end
        negA = signA & exers_op1[31];
        negB = signB & exers_op2[31];
        absA = negA ? (~exers_op1 + 32'd1) : exers_op1;
        absB = negB ? (~exers_op2 + 32'd1) : exers_op2;
        if (isMul) begin
            issueNeg = negA ^ negB;
        end else if (!exers_mcalu_op[1]) begin
            issueNeg = negA ^ negB;
        end else begin
            issueNeg = negA;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus the sign/zero fix-up of the final step.
    always_comb begin
        mulSum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
        mulNext    = {mulSum, prod_q[31:1]};

        divShifted = {rem_q, prod_q[31]};
        divGeq     = (divShifted >= {1'b0, opnd_q});
        divSub     = divShifted[31:0] - opnd_q;
        remNext    = divGeq ? divSub : divShifted[31:0];
        quoNext    = {prod_q[30:0], divGeq};

        prodFixed  = neg_q ? (~mulNext + 64'd1) : mulNext;
        quoFixed   = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~quoNext + 32'd1) : quoNext);
        // With a zero divisor the remainder ends up as |op1|; the dividend-sign fix-up restores op1 exactly.
        remFixed   = neg_q ? (~remNext + 32'd1) : remNext;

        if (!op_q[2]) begin
            finalResult = (op_q == 3'b000) ? prodFixed[31:0] : prodFixed[63:32];
        end else if (!op_q[1]) begin
            finalResult = quoFixed;
        end else begin
            finalResult = remFixed;
        end
    end

    // Next-state logic: issue in IDLE, iterate in CALC, hold the result in DONE until writeback takes it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        robid_d  = robid_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;

        if (rob_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exers_mcalu_issue && isMcaluOp) begin
                        op_d    = exers_mcalu_op[2:0];
                        robid_d = exers_robid;
                        rd_d    = exers_rd;
                        neg_d   = issueNeg;
                        dz_d    = (exers_op2 == 32'd0);
                        rem_d   = 32'd0;
                        cnt_d   = 6'd0;
                        if (isMul) begin
                            opnd_d = absA;
                            prod_d = {32'd0, absB};
                        end else begin
                            opnd_d = absB;
                            prod_d = {32'd0, absA};
                        end
                        state_d = CALC;
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 6'd1;
                    if (!op_q[2]) begin
                        prod_d = mulNext;
                    end else begin
                        prod_d = {32'd0, quoNext};
                        rem_d  = remNext;
                    end
                    if (cnt_q == 6'd31) begin
                        result_d = finalResult;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (!wb_mcalu_stall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, all cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            robid_q  <= 7'd0;
            rd_q     <= 6'd0;
            opnd_q   <= 32'd0;
            prod_q   <= 64'd0;
            rem_q    <= 32'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            robid_q  <= robid_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    // Outputs come straight from registers so they are stable while writeback stalls.
    always_comb begin
        mcalu_stall  = (state_q != IDLE);
        mcalu_valid  = (state_q == DONE);
        mcalu_robid  = robid_q;
        mcalu_rd     = rd_q;
        mcalu_result = result_q;
    end

endmodule

// File: tb/tb_mcalu.sv
// tb_mcalu: table-driven and randomized checks of the mcalu multi-cycle ALU.
module tb_mcalu;

    logic        clk;
    logic        rst;
    logic        issue;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        wbStall;
    logic        flush;
    logic        mcalu_stall;
    logic        mcalu_valid;
    logic [6:0]  mcalu_robid;
    logic [5:0]  mcalu_rd;
    logic [31:0] mcalu_result;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  robid;
        logic [5:0]  rd;
        int          stallCycles;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    mcalu dut (
        .clk               (clk),
        .rst               (rst),
        .exers_mcalu_issue (issue),
        .exers_mcalu_op    (op),
        .exers_robid       (robid),
        .exers_rd          (rd),
        .exers_op1         (op1),
        .exers_op2         (op2),
        .mcalu_stall       (mcalu_stall),
        .mcalu_valid       (mcalu_valid),
        .mcalu_robid       (mcalu_robid),
        .mcalu_rd          (mcalu_rd),
        .mcalu_result      (mcalu_result),
        .wb_mcalu_stall    (wbStall),
        .rob_flush         (flush)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reservation stations never issue into a busy unit; flag it if the bench ever does.
    always @(posedge clk) begin
        if (rst && issue && mcalu_stall) begin
            $display("[TB] FAIL issue_while_stall: issue=%0b stall=%0b, required no issue while busy", issue, mcalu_stall);
            failCount++;
        end
    end

    // Reference model computed directly from the RV32M arithmetic definitions.
    function automatic logic [31:0] refModel(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (f)
            3'd0: begin p = 64'(ua * ub); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at the current negedge (unit idle) and follow it through CALC, DONE and back to IDLE.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [6:0] rid, input logic [5:0] rdTag,
                                 input int stallCycles, input logic [31:0] exp);
        int badStall;
        int badValid;
        int badHold;
        badStall = 0;
        badValid = 0;
        badHold  = 0;
        checkOutput("idle_before_issue", {31'd0, mcalu_stall}, 32'd0);
        issue = 1'b1;
        op    = {2'b11, f};
        op1   = a;
        op2   = b;
        robid = rid;
        rd    = rdTag;
        @(negedge clk);
        issue = 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        for (int k = 1; k <= 32; k++) begin
            if (!mcalu_stall) badStall++;
            if (mcalu_valid) badValid++;
            @(negedge clk);
        end
        checkOutput("stall_during_calc", badStall, 0);
        checkOutput("valid_before_33", badValid, 0);
        checkOutput("valid_at_33", {31'd0, mcalu_valid}, 32'd1);
        checkOutput("stall_at_33", {31'd0, mcalu_stall}, 32'd1);
        checkOutput("result", mcalu_result, exp);
        checkOutput("robid", {25'd0, mcalu_robid}, {25'd0, rid});
        checkOutput("rd", {26'd0, mcalu_rd}, {26'd0, rdTag});
        wbStall = (stallCycles > 0);
        for (int i = 1; i <= stallCycles; i++) begin
            @(negedge clk);
            if (!mcalu_valid || mcalu_result !== exp || mcalu_robid !== rid || mcalu_rd !== rdTag) badHold++;
            wbStall = (i < stallCycles);
        end
        if (stallCycles > 0) checkOutput("held_under_wb_stall", badHold, 0);
        @(negedge clk);
        checkOutput("valid_after_accept", {31'd0, mcalu_valid}, 32'd0);
        checkOutput("stall_after_accept", {31'd0, mcalu_stall}, 32'd0);
    endtask

    // Main sequence: reset, directed table, flush and reset corners, then randomized ops.
    initial begin
        int quiet;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 7'd5,  6'd9,  0, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 7'd1,  6'd2,  0, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd2,  6'd3,  0, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd3,  6'd4,  0, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         7'd4,  6'd5,  0, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         7'd6,  6'd6,  0, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd0,         7'd7,  6'd7,  0, 32'hFFFF_FFFF};
        vecs[7]  = '{3'd6, 32'd100,       32'd0,         7'd8,  6'd8,  0, 32'd100};
        vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 7'd9,  6'd10, 0, 32'h8000_0000};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 7'd10, 6'd11, 4, 32'd0};
        vecs[10] = '{3'd4, 32'hFFFF_FF9C, 32'd0,         7'd11, 6'd12, 0, 32'hFFFF_FFFF};
        vecs[11] = '{3'd7, 32'hFFFF_FF9C, 32'd0,         7'd12, 6'd13, 1, 32'hFFFF_FF9C};
        vecs[12] = '{3'd6, 32'hFFFF_FF9C, 32'd0,         7'd13, 6'd14, 0, 32'hFFFF_FF9C};

        rst     = 1'b0;
        issue   = 1'b0;
        op      = 5'b11000;
        robid   = 7'd0;
        rd      = 6'd0;
        op1     = 32'd0;
        op2     = 32'd0;
        wbStall = 1'b0;
        flush   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_stall", {31'd0, mcalu_stall}, 32'd0);
        checkOutput("reset_valid", {31'd0, mcalu_valid}, 32'd0);
        checkOutput("reset_result", mcalu_result, 32'd0);
        checkOutput("reset_robid_rd", {19'd0, mcalu_robid, mcalu_rd}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].robid, vecs[i].rd,
                          vecs[i].stallCycles, vecs[i].exp);
        end

        // Flush of a DIV at T+10 drops it.
        issue = 1'b1; op = 5'b11100; op1 = 32'd100; op2 = 32'd7; robid = 7'd20; rd = 6'd20;
        @(negedge clk);
        issue = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_stall", {31'd0, mcalu_stall}, 32'd0);
        checkOutput("flush_valid", {31'd0, mcalu_valid}, 32'd0);
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            if (mcalu_valid || mcalu_stall) quiet++;
            @(negedge clk);
        end
        checkOutput("flush_no_writeback", quiet, 0);

        // Issue coinciding with flush is not accepted.
        issue = 1'b1; flush = 1'b1; op = 5'b11000; op1 = 32'd3; op2 = 32'd3;
        @(negedge clk);
        issue = 1'b0; flush = 1'b0;
        checkOutput("flush_issue_stall", {31'd0, mcalu_stall}, 32'd0);
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            if (mcalu_valid || mcalu_stall) quiet++;
            @(negedge clk);
        end
        checkOutput("flush_issue_ignored", quiet, 0);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        issue = 1'b1; op = 5'b11000; op1 = 32'd5; op2 = 32'd6; robid = 7'd33; rd = 6'd33;
        @(negedge clk);
        issue = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_stall", {31'd0, mcalu_stall}, 32'd0);
        checkOutput("async_reset_valid", {31'd0, mcalu_valid}, 32'd0);
        checkOutput("async_reset_result", mcalu_result, 32'd0);
        checkOutput("async_reset_robid_rd", {19'd0, mcalu_robid, mcalu_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(3'd0, 32'd3, 32'd4, 7'd40, 6'd41, 0, 32'd12);

        // Randomized ops against the reference model, biased toward corner operands.
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            applyStimulus(rf, ra, rb, 7'($urandom), 6'($urandom), $urandom_range(0, 2),
                          refModel(rf, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mcalu.md
# mcalu

Multi-cycle ALU for integer multiply/divide/remainder (RV32M), directly downstream of the execute reservation stations. Two instances exist (mcalu0/mcalu1). Each accepts one op at a time from the reservation stations, computes it iteratively over a fixed latency, and presents the result to the writeback arbiter with a valid/stall handshake. `mcalu_stall` tells the reservation stations that the unit cannot accept an op.

## Interface
- No parameters; datapath fixed at 32 bits, 32 iterations.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `exers_mcalu_issue` in 1: issue strobe for this instance.
- `exers_mcalu_op` in 5: op; bits [4:3] are always 2'b11 for mcalu ops; [2:0] select the function.
- `exers_robid` in 7: ROB id of the issued op.
- `exers_rd` in 6: destination tag.
- `exers_op1` in 32: rs1 value.
- `exers_op2` in 32: rs2 value.
- `mcalu_stall` out 1: unit busy; no issue is accepted while high.
- `mcalu_valid` out 1: result valid toward writeback.
- `mcalu_robid` out 7: ROB id of the result.
- `mcalu_rd` out 6: destination tag of the result.
- `mcalu_result` out 32: result.
- `wb_mcalu_stall` in 1: writeback arbiter did not take the result this cycle.
- `rob_flush` in 1: discard all in-flight work.

## Operation
- Function select op[2:0]:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed op1 × unsigned op2.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- FSM states: IDLE, CALC, DONE.
- IDLE: on `exers_mcalu_issue & ~rob_flush`:
  - latch robid, rd and op.
  - Latch operand magnitudes: take the absolute value only for operands that the op treats as signed.
  - Record the result-sign flag.
  - Clear the 6-bit iteration counter; go to CALC.
- CALC: one iteration per cycle; counter increments 0..31. At count 31, go to DONE.
  - Multiply: unsigned shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract; 32-bit quotient and 33-bit partial remainder.
- Entry to DONE registers the final result:
  - Product negated (64-bit two's complement) if the sign flag is set; then select the low or high word.
  - DIV quotient negated if operand signs differ.
  - REM remainder negated if the dividend is negative.
- Divide by zero (op2==0), overrides any sign fix-up:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU result = op1 unmodified.
- Signed overflow (0x80000000 / 0xFFFFFFFF) falls out naturally; no override:
  - DIV = 0x80000000.
  - REM = 0.
- DONE: `mcalu_valid`=1 with robid/rd/result held stable. Go to IDLE at the first edge where `wb_mcalu_stall`=0.
- `mcalu_stall` = (state != IDLE).
- `rob_flush` in any state forces IDLE at the next edge and drops the pending result. An issue in the same cycle as a flush is ignored.
- `mcalu_robid`, `mcalu_rd` and `mcalu_result` are don't-care when `mcalu_valid`=0; implementation holds the last values.

## Timing
- Reset (rst=0, async): state IDLE, counter 0, and all outputs 0 (`mcalu_stall`=0, `mcalu_valid`=0, `mcalu_result`/`robid`/`rd`=0).
- Issue sampled in cycle T:
  - `mcalu_stall`=1 from T+1.
  - CALC occupies T+1..T+32.
  - `mcalu_valid`=1 first in T+33.
- Latency is fixed at 33 cycles for all ops, including divide-by-zero.
- If `wb_mcalu_stall`=0 in T+33: `mcalu_valid`=0 and `mcalu_stall`=0 in T+34, and a new issue is accepted in T+34.
- Each stall cycle extends DONE by one cycle; outputs do not change while stalled.
- Issue while `mcalu_stall`=1 is illegal: the RS never does this, and the bench asserts it never happens. The unit ignores it.
- Flush in cycle F: `mcalu_valid`=0 and `mcalu_stall`=0 in F+1.
- Async reset asserted mid-CALC or in DONE: outputs clear immediately, with no writeback.

## Test plan
- Reset then MUL: op1=7, op2=-3 (0xFFFFFFFD), robid 5, rd 9, issue at T. Required: `mcalu_valid` first in T+33 with result 0xFFFFFFEB, robid 5, rd 9; `mcalu_stall` high for T+1..T+33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide corners:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/0 → 0xFFFFFFFF; REM 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure: `wb_mcalu_stall`=1 for 4 cycles from T+33. Required: valid and result held through T+37; IDLE and stall=0 at T+38; a back-to-back issue at T+38 yields valid at T+71.
- Flush: `rob_flush` at T+10 of a DIV. Required: valid never asserts, stall=0 at T+11. Flush coinciding with an issue: not accepted.
- Async reset (rst=0) mid-CALC: outputs 0 without waiting for a clock edge. After release, a fresh MUL 3×4 → 12 in 33 cycles.
